// File: rtl/alu_issue_stage_pkg.sv
// Shared decode constants, ALU op bit indices and the decoded-instruction types
// used by the ALU issue stage.
package alu_issue_stage_pkg;

  localparam int DATA_W = 32;
  localparam int OP_N   = 12;
  localparam int REG_W  = 5;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0a;
  localparam logic [5:0] OPC_SLTIU   = 6'h0b;
  localparam logic [5:0] OPC_ANDI    = 6'h0c;
  localparam logic [5:0] OPC_ORI     = 6'h0d;
  localparam logic [5:0] OPC_XORI    = 6'h0e;
  localparam logic [5:0] OPC_LUI     = 6'h0f;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam int unsigned ALU_OP_ADD  = 0;
  localparam int unsigned ALU_OP_SUB  = 1;
  localparam int unsigned ALU_OP_SLT  = 2;
  localparam int unsigned ALU_OP_SLTU = 3;
  localparam int unsigned ALU_OP_AND  = 4;
  localparam int unsigned ALU_OP_NOR  = 5;
  localparam int unsigned ALU_OP_OR   = 6;
  localparam int unsigned ALU_OP_XOR  = 7;
  localparam int unsigned ALU_OP_SLL  = 8;
  localparam int unsigned ALU_OP_SRL  = 9;
  localparam int unsigned ALU_OP_SRA  = 10;
  localparam int unsigned ALU_OP_LUI  = 11;

  typedef enum logic [1:0] {SRC1_ZERO, SRC1_RS, SRC1_SHAMT} src1_sel_e;
  typedef enum logic [1:0] {SRC2_ZERO, SRC2_RT, SRC2_SIMM, SRC2_ZIMM} src2_sel_e;

  typedef struct packed {
    logic [OP_N-1:0]  alu_op;
    src1_sel_e        src1_sel;
    src2_sel_e        src2_sel;
    logic [REG_W-1:0] dest;
    logic             we;
    logic             illegal;
  } dec_ctrl_t;

  typedef struct packed {
    logic [OP_N-1:0]   alu_op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [REG_W-1:0]  dest;
    logic              we;
    logic              illegal;
  } issue_entry_t;

  function automatic logic [OP_N-1:0] op_onehot(input int unsigned idx);
    op_onehot = {{(OP_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/alu_issue_stage_alu_op_decode.sv
// Combinational MIPS decode: instruction plus register-file read data in,
// resolved ALU command entry out.
module alu_op_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output issue_entry_t      entry
);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [4:0]       shamt;
  logic [15:0]      imm;
  dec_ctrl_t        ctrl;

  assign opcode = inst[31:26];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign shamt  = inst[10:6];
  assign funct  = inst[5:0];
  assign imm    = inst[15:0];

  always_comb begin
    ctrl          = '0;
    ctrl.src1_sel = SRC1_ZERO;
    ctrl.src2_sel = SRC2_ZERO;
    ctrl.illegal  = 1'b1;
    case (opcode)
      OPC_SPECIAL: begin
        ctrl.illegal  = 1'b0;
        ctrl.dest     = rd;
        ctrl.src1_sel = SRC1_RS;
        ctrl.src2_sel = SRC2_RT;
        case (funct)
          FN_ADDU: ctrl.alu_op = op_onehot(ALU_OP_ADD);
          FN_SUBU: ctrl.alu_op = op_onehot(ALU_OP_SUB);
          FN_SLT:  ctrl.alu_op = op_onehot(ALU_OP_SLT);
          FN_SLTU: ctrl.alu_op = op_onehot(ALU_OP_SLTU);
          FN_AND:  ctrl.alu_op = op_onehot(ALU_OP_AND);
          FN_NOR:  ctrl.alu_op = op_onehot(ALU_OP_NOR);
          FN_OR:   ctrl.alu_op = op_onehot(ALU_OP_OR);
          FN_XOR:  ctrl.alu_op = op_onehot(ALU_OP_XOR);
          FN_SLLV: ctrl.alu_op = op_onehot(ALU_OP_SLL);
          FN_SRLV: ctrl.alu_op = op_onehot(ALU_OP_SRL);
          FN_SRAV: ctrl.alu_op = op_onehot(ALU_OP_SRA);
          FN_SLL: begin
            ctrl.alu_op   = op_onehot(ALU_OP_SLL);
            ctrl.src1_sel = SRC1_SHAMT;
          end
          FN_SRL: begin
            ctrl.alu_op   = op_onehot(ALU_OP_SRL);
            ctrl.src1_sel = SRC1_SHAMT;
          end
          FN_SRA: begin
            ctrl.alu_op   = op_onehot(ALU_OP_SRA);
            ctrl.src1_sel = SRC1_SHAMT;
          end
          default: begin
            ctrl          = '0;
            ctrl.src1_sel = SRC1_ZERO;
            ctrl.src2_sel = SRC2_ZERO;
            ctrl.illegal  = 1'b1;
          end
        endcase
      end
      OPC_ADDIU, OPC_SLTI, OPC_SLTIU, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI: begin
        ctrl.illegal  = 1'b0;
        ctrl.dest     = rt;
        ctrl.src1_sel = SRC1_RS;
        ctrl.src2_sel = SRC2_ZIMM;
        case (opcode)
          OPC_ADDIU: begin ctrl.alu_op = op_onehot(ALU_OP_ADD);  ctrl.src2_sel = SRC2_SIMM; end
          OPC_SLTI:  begin ctrl.alu_op = op_onehot(ALU_OP_SLT);  ctrl.src2_sel = SRC2_SIMM; end
          OPC_SLTIU: begin ctrl.alu_op = op_onehot(ALU_OP_SLTU); ctrl.src2_sel = SRC2_SIMM; end
          OPC_ANDI:  ctrl.alu_op = op_onehot(ALU_OP_AND);
          OPC_ORI:   ctrl.alu_op = op_onehot(ALU_OP_OR);
          OPC_XORI:  ctrl.alu_op = op_onehot(ALU_OP_XOR);
          default:   ctrl.alu_op = op_onehot(ALU_OP_LUI);
        endcase
      end
      default: ;
    endcase
    // Writes to r0 are dropped here so execute never needs to special-case it.
    ctrl.we = !ctrl.illegal && (ctrl.dest != '0);
  end

  always_comb begin
    entry         = '0;
    entry.alu_op  = ctrl.alu_op;
    entry.dest    = ctrl.dest;
    entry.we      = ctrl.we;
    entry.illegal = ctrl.illegal;
    case (ctrl.src1_sel)
      SRC1_RS:    entry.src1 = rf_rdata1;
      SRC1_SHAMT: entry.src1 = {{(DATA_W-5){1'b0}}, shamt};
      default:    entry.src1 = '0;
    endcase
    case (ctrl.src2_sel)
      SRC2_RT:   entry.src2 = rf_rdata2;
      SRC2_SIMM: entry.src2 = {{(DATA_W-16){imm[15]}}, imm};
      SRC2_ZIMM: entry.src2 = {{(DATA_W-16){1'b0}}, imm};
      default:   entry.src2 = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: registered output slot with a one-entry skid buffer and a
// completed-issue counter. Decode lives in alu_op_decode.
//
// state | meaning
// EMPTY | nothing to issue, out_valid low
// ONE   | output register valid, skid buffer empty
// FULL  | output register and skid buffer both valid
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_NUM     = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  output logic [4:0]            rf_raddr1,
  output logic [4:0]            rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_NUM-1:0]     out_alu_op,
  output logic [DATA_WIDTH-1:0] out_alu_src1,
  output logic [DATA_WIDTH-1:0] out_alu_src2,
  output logic [4:0]            out_dest,
  output logic                  out_rf_we,
  output logic                  out_illegal,
  output logic [31:0]           issue_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e       state, state_nxt;
  issue_entry_t dec_entry, out_q, skid_q;
  logic         accept, drain;
  logic         load_out, load_skid, out_from_skid;

  assign rf_raddr1 = in_inst[25:21];
  assign rf_raddr2 = in_inst[20:16];

  alu_op_decode u_decode (
    .inst      (in_inst),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .entry     (dec_entry)
  );

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        load_out  = 1'b1;
      end
      ONE: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (drain) begin
        state_nxt     = ONE;
        out_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready is registered: it reflects whether the skid buffer will be free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)           out_q <= dec_entry;
      else if (out_from_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec_entry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    issue_count <= '0;
    else if (drain) issue_count <= issue_count + 32'd1;
  end

  assign out_alu_op   = out_q.alu_op;
  assign out_alu_src1 = out_q.src1;
  assign out_alu_src2 = out_q.src2;
  assign out_dest     = out_q.dest;
  assign out_rf_we    = out_q.we;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, back-pressure and reset
// sequences, then random traffic against a queue-based reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, rf_rdata1, rf_rdata2;
  logic [4:0]  rf_raddr1, rf_raddr2, out_dest;
  logic [11:0] out_alu_op;
  logic [31:0] out_alu_src1, out_alu_src2, issue_count;
  logic        out_rf_we, out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32), .OP_NUM(12)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2),
    .out_dest(out_dest), .out_rf_we(out_rf_we), .out_illegal(out_illegal),
    .issue_count(issue_count)
  );

  typedef struct packed {
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dest;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] r1;
    logic [31:0] r2;
    exp_t        e;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vec[10];

  function automatic exp_t mkexp(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [4:0] dest, input logic we, input logic ill);
    exp_t e;
    e.op = op; e.s1 = s1; e.s2 = s2; e.dest = dest; e.we = we; e.ill = ill;
    return e;
  endfunction

  // Legal instruction: one-hot bit at position idx, register write unless r0.
  function automatic exp_t legal(input int idx, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [4:0] dest);
    return mkexp(12'(1) << idx, s1, s2, dest, dest != 5'd0, 1'b0);
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] se, ze, sh;
    logic [4:0]  rt, rd;
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    sh = {27'h0, i[10:6]};
    rt = i[20:16];
    rd = i[15:11];
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h21: return legal(0, a, b, rd);
        6'h23: return legal(1, a, b, rd);
        6'h2a: return legal(2, a, b, rd);
        6'h2b: return legal(3, a, b, rd);
        6'h24: return legal(4, a, b, rd);
        6'h27: return legal(5, a, b, rd);
        6'h25: return legal(6, a, b, rd);
        6'h26: return legal(7, a, b, rd);
        6'h00: return legal(8, sh, b, rd);
        6'h02: return legal(9, sh, b, rd);
        6'h03: return legal(10, sh, b, rd);
        6'h04: return legal(8, a, b, rd);
        6'h06: return legal(9, a, b, rd);
        6'h07: return legal(10, a, b, rd);
        default: return mkexp(12'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
      endcase
    end
    case (i[31:26])
      6'h09: return legal(0, a, se, rt);
      6'h0a: return legal(2, a, se, rt);
      6'h0b: return legal(3, a, se, rt);
      6'h0c: return legal(4, a, ze, rt);
      6'h0d: return legal(6, a, ze, rt);
      6'h0e: return legal(7, a, ze, rt);
      6'h0f: return legal(11, a, ze, rt);
      default: return mkexp(12'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"},    32'(out_alu_op), 32'(e.op));
    chk({tag, ".src1"},  out_alu_src1, e.s1);
    chk({tag, ".src2"},  out_alu_src2, e.s2);
    chk({tag, ".dest"},  32'(out_dest), 32'(e.dest));
    chk({tag, ".we"},    32'(out_rf_we), 32'(e.we));
    chk({tag, ".ill"},   32'(out_illegal), 32'(e.ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_inst   = v.inst;
    rf_rdata1 = v.r1;
    rf_rdata2 = v.r2;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd0);
    chk("rst.count", issue_count, 32'd0);
    chk("rst.op",    32'(out_alu_op), 32'd0);
    chk("rst.src2",  out_alu_src2, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("rst.ready_after", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] gen_inst();
    logic [5:0]  fl[14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21,
                            6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    logic [31:0] r;
    int k;
    r = $urandom;
    k = int'($urandom_range(0, 9));
    if (k < 4) begin
      r[31:26] = 6'h00;
      r[5:0]   = fl[$urandom_range(0, 13)];
    end else if (k < 8) begin
      r[31:26] = 6'(6'h09 + 6'($urandom_range(0, 6)));
    end
    return r;
  endfunction

  initial begin
    exp_t        q[$];
    logic        rdy_m;
    logic [31:0] cnt_m;
    logic        acc, drn;
    logic [31:0] inst;

    vec[0] = '{32'h2422FFFF, 32'd5,        32'h0,        mkexp(12'h001, 32'd5, 32'hFFFFFFFF, 5'd2, 1'b1, 1'b0)};
    vec[1] = '{32'h000419C3, 32'h11,       32'h80000000, mkexp(12'h400, 32'd7, 32'h80000000, 5'd3, 1'b1, 1'b0)};
    vec[2] = '{32'h3C051234, 32'h0,        32'h5555,     mkexp(12'h800, 32'h0, 32'h00001234, 5'd5, 1'b1, 1'b0)};
    vec[3] = '{32'h34000001, 32'h0000F0F0, 32'h0,        mkexp(12'h040, 32'h0000F0F0, 32'd1, 5'd0, 1'b0, 1'b0)};
    vec[4] = '{32'hFC000000, 32'h1234,     32'h5678,     mkexp(12'h000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1)};
    vec[5] = '{32'h00430823, 32'd100,      32'd40,       mkexp(12'h002, 32'd100, 32'd40, 5'd1, 1'b1, 1'b0)};
    vec[6] = '{32'h00853004, 32'h23,       32'hABCD0000, mkexp(12'h100, 32'h23, 32'hABCD0000, 5'd6, 1'b1, 1'b0)};
    vec[7] = '{32'h30858001, 32'hFFFFFFFF, 32'h0,        mkexp(12'h010, 32'hFFFFFFFF, 32'h00008001, 5'd5, 1'b1, 1'b0)};
    vec[8] = '{32'h28A68000, 32'h7,        32'h0,        mkexp(12'h004, 32'h7, 32'hFFFF8000, 5'd6, 1'b1, 1'b0)};
    vec[9] = '{32'h03E00008, 32'h9,        32'h9,        mkexp(12'h000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1)};

    in_inst = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    do_reset();

    // Back-to-back table at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vec[i]);
      inst = vec[i].inst;
      #1;
      chk($sformatf("vec%0d.raddr1", i), 32'(rf_raddr1), 32'(inst[25:21]));
      chk($sformatf("vec%0d.raddr2", i), 32'(rf_raddr2), 32'(inst[20:16]));
      chk($sformatf("vec%0d.ready", i), 32'(in_ready), 32'd1);
      tick();
      chk_out($sformatf("vec%0d", i), vec[i].e);
    end
    in_valid = 1'b0;
    tick();
    chk("vec.drained", 32'(out_valid), 32'd0);
    chk("vec.count", issue_count, 32'd10);

    // Back-pressure: three back-to-back with out_ready low.
    do_reset();
    drive(vec[0]); #1;
    chk("bp.ready0", 32'(in_ready), 32'd1);
    tick();
    drive(vec[1]); #1;
    chk("bp.ready1", 32'(in_ready), 32'd1);
    chk_out("bp.A", vec[0].e);
    tick();
    drive(vec[2]); #1;
    chk("bp.ready2", 32'(in_ready), 32'd0);
    chk_out("bp.A_hold", vec[0].e);
    tick();
    chk("bp.ready3", 32'(in_ready), 32'd0);
    chk_out("bp.A_hold2", vec[0].e);
    out_ready = 1'b1;
    tick();
    chk_out("bp.B", vec[1].e);
    chk("bp.ready_rise", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp.C", vec[2].e);
    in_valid = 1'b0;
    tick();
    chk("bp.empty", 32'(out_valid), 32'd0);
    chk("bp.count", issue_count, 32'd3);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    drive(vec[5]); tick();
    drive(vec[6]); tick();
    in_valid = 1'b0; #1;
    chk("mr.full_ready", 32'(in_ready), 32'd0);
    resetn = 1'b0;
    #1;
    chk("mr.valid", 32'(out_valid), 32'd0);
    chk("mr.count", issue_count, 32'd0);
    chk("mr.ready", 32'(in_ready), 32'd0);
    chk("mr.op",    32'(out_alu_op), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("mr.ready_after", 32'(in_ready), 32'd1);
    chk("mr.no_stale", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    drive(vec[7]);
    tick();
    chk_out("mr.next", vec[7].e);
    in_valid = 1'b0;
    tick();
    chk("mr.empty", 32'(out_valid), 32'd0);
    chk("mr.count1", issue_count, 32'd1);

    // Random traffic against the queue model.
    do_reset();
    rdy_m = 1'b1;
    cnt_m = 32'd0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_inst   = gen_inst();
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      #1;
      chk("rnd.ready", 32'(in_ready), 32'(rdy_m));
      chk("rnd.count", issue_count, cnt_m);
      if (q.size() > 0) chk_out("rnd.out", q[0]);
      else chk("rnd.valid", 32'(out_valid), 32'd0);
      acc = in_valid && rdy_m;
      drn = (q.size() > 0) && out_ready;
      if (acc) q.push_back(ref_decode(in_inst, rf_rdata1, rf_rdata2));
      tick();
      if (drn) begin
        void'(q.pop_front());
        cnt_m = cnt_m + 32'd1;
      end
      rdy_m = (q.size() < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage that produces the ALU's command word. It accepts 32-bit MIPS instructions from fetch and reads source registers from the register file. It then issues the one-hot `alu_op` and the `alu_src1`/`alu_src2` operands to the execute stage through a registered valid/ready pipeline slot backed by a one-entry skid buffer.

## Interface
- `DATA_WIDTH`, 32: operand width; instruction format fixes it at 32.
- `OP_NUM`, 12: width of the one-hot ALU op. Bit order: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (bits 0..11).
- `clk`  in  1  single clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `in_valid` / `in_ready`  in / out  1 each  fetch handshake.
- `in_inst`  in  32  instruction.
- `rf_raddr1`, `rf_raddr2`  out  5 each  register file read addresses; combinational from `in_inst` rs and rt.
- `rf_rdata1`, `rf_rdata2`  in  DATA_WIDTH each  register file read data, valid in the same cycle.
- `out_valid` / `out_ready`  out / in  1 each  execute handshake.
- `out_alu_op`  out  OP_NUM  one-hot op, or all-zero.
- `out_alu_src1`, `out_alu_src2`  out  DATA_WIDTH each  operands.
- `out_dest`  out  5  destination register.
- `out_rf_we`  out  1  writeback enable.
- `out_illegal`  out  1  unsupported encoding.
- `issue_count`  out  32  count of completed output handshakes; wraps.

## Operation
- Decode of R-type (opcode 0):
  - Funct 0x21 addu, 0x23 subu, 0x2a slt, 0x2b sltu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - Funct 0x00/0x02/0x03 sll/srl/sra use src1 = zero-extended shamt.
  - Funct 0x04/0x06/0x07 sllv/srlv/srav use src1 = rs.
  - Dest is rd. All other R-type ops have src1 = rs, src2 = rt.
- Decode of I-type (dest is rt, src1 = rs):
  - 0x09 addiu, 0x0a slti, 0x0b sltiu: src2 = sign-extended imm16.
  - 0x0c andi, 0x0d ori, 0x0e xori: src2 = zero-extended imm16.
  - 0x0f lui: src2 = zero-extended imm16; the ALU performs the shift to the upper half.
- Shift ops: the ALU shifts src2 by src1[4:0].
- Any other encoding: `alu_op` = 0, `rf_we` = 0, `illegal` = 1. Operands are don't-care but deterministic (0).
- `rf_we` = 0 whenever dest is 0.
- Operands are captured in the accept cycle. Hazard interlock and forwarding are outside this block.
- Slot states:
  - EMPTY: `out_valid` = 0.
  - ONE: output register valid, skid buffer empty.
  - FULL: both valid.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→ONE on accept together with drain.
  - ONE→FULL on accept without drain; the new entry goes to the skid buffer.
  - ONE→EMPTY on drain without accept.
  - FULL→ONE on drain; the skid buffer moves to the output register.
- `in_ready` is a registered signal, equal to "skid buffer empty next cycle". No accept occurs in FULL.
- Order is strictly preserved. No entry is dropped or duplicated.
- `issue_count` increments on each `out_valid & out_ready` and wraps 0xFFFFFFFF→0.

## Timing
- Latency: instruction accepted at edge N appears on the outputs after edge N, i.e. usable at edge N+1.
- Throughput: one instruction per cycle while `out_ready` = 1.
- Output stability: while `out_valid` = 1 and `out_ready` = 0, all `out_*` stay stable.
- Simultaneous accept and drain in ONE: the output register loads the new entry, and the state stays ONE.
- Back-pressure: `in_ready` falls the cycle after the accept that fills the skid buffer. It rises the cycle after the drain that empties it.
- Reset values, applied asynchronously on `resetn` low:
  - `out_valid` = 0, `in_ready` = 0.
  - All `out_*` data outputs = 0.
  - `issue_count` = 0.
  - State = EMPTY; any in-flight entries are discarded.
- After reset release, `in_ready` = 1 from the first rising edge onward.

## Structure
- Shared package holds:
  - Opcode and funct constants.
  - `ALU_OP_*` bit-index constants (0..11).
  - A decoded-instruction struct: op, src-select fields, dest, we, illegal.
- The ALU-facing bit indices live only in the package.
- Sub-module `alu_op_decode` (purely combinational): instruction plus rf data in, decoded struct out.
- `alu_issue_stage` holds only the slot/skid control, the registers and the counter.

## Test plan
- ADDIU, `0x2422FFFF`, with `rf_rdata1` = 5 → next cycle:
  - `alu_op` = 0x001, src1 = 5, src2 = 0xFFFFFFFF, dest = 2, `rf_we` = 1.
- SRA, `0x000419C3`, with `rf_rdata2` = 0x80000000 → `alu_op` = 0x400, src1 = 7, src2 = 0x80000000, dest = 3.
- LUI, `0x3C051234` → `alu_op` = 0x800, src2 = 0x00001234, dest = 5.
- ORI with rt = 0, `0x34000001` → `rf_we` = 0.
- Opcode 0x3F, `0xFC000000` → `alu_op` = 0, `illegal` = 1, `rf_we` = 0.
- Back-pressure: hold `out_ready` = 0 and drive 3 back-to-back valid instructions → 2 accepted, `in_ready` = 0 on the 3rd.
  - Then `out_ready` = 1 → all 3 drain in order on consecutive cycles, and `issue_count` = 3.
- Reset mid-operation: assert `resetn` low asynchronously while FULL → `out_valid` = 0, `issue_count` = 0, `in_ready` = 0.
  - After release, the next instruction issues normally with no stale entry.
